gray_converter: RTL

GRAY_CONVERTER -- requirements
Module: gray_converter

---
 rtl/gray_converter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/gray_converter.sv
// RGB byte-stream to 8-bit grayscale converter for an N x M frame.
// Collects R, G, B bytes, computes (77R + 150G + 29B) >> 8, hands the pixel downstream.
module gray_converter #(
  parameter int unsigned N = 2,
  parameter int unsigned M = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gs_enable,
  input  logic       rgb_valid,
  input  logic [7:0] rgb_data,
  output logic       rgb_ready,
  output logic [7:0] gray_data,
  output logic       GS_valid,
  input  logic       gray_ready,
  output logic       GS_done
);

  localparam int unsigned PIX = N * M;
  localparam int unsigned CW  = (PIX > 1) ? $clog2(PIX) : 1;
  localparam logic [CW-1:0] LAST = CW'(PIX - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_R,
    GET_G,
    GET_B,
    CALC,
    OUT,
    DONE
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [7:0]    r, r_next;
  logic [7:0]    g, g_next;
  logic [7:0]    b, b_next;
  logic [7:0]    gray_next;
  logic          rgb_ready_next;
  logic          gs_valid_next;
  logic          gs_done_next;
  logic [15:0]   sum_c;

  // Weighted luma sum; weights total 256 so the maximum is 65280 and fits 16 bits.
  assign sum_c = 16'd77 * {8'd0, r} + 16'd150 * {8'd0, g} + 16'd29 * {8'd0, b};

  // State and datapath registers; outputs are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      r         <= '0;
      g         <= '0;
      b         <= '0;
      gray_data <= '0;
      rgb_ready <= 1'b0;
      GS_valid  <= 1'b0;
      GS_done   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      r         <= r_next;
      g         <= g_next;
      b         <= b_next;
      gray_data <= gray_next;
      rgb_ready <= rgb_ready_next;
      GS_valid  <= gs_valid_next;
      GS_done   <= gs_done_next;
    end
  end

  // Next-state logic; losing gs_enable aborts the frame from any state.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    r_next     = r;
    g_next     = g;
    b_next     = b;
    gray_next  = gray_data;

    if (!gs_enable) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_next   = '0;
          state_next = GET_R;
        end
        GET_R: if (rgb_valid) begin
          r_next     = rgb_data;
          state_next = GET_G;
        end
        GET_G: if (rgb_valid) begin
          g_next     = rgb_data;
          state_next = GET_B;
        end
        GET_B: if (rgb_valid) begin
          b_next     = rgb_data;
          state_next = CALC;
        end
        CALC: begin
          gray_next  = 8'(sum_c >> 8);
          state_next = OUT;
        end
        OUT: if (gray_ready) begin
          if (cnt == LAST) begin
            state_next = DONE;
          end else begin
            cnt_next   = cnt + CW'(1);
            state_next = GET_R;
          end
        end
        DONE: begin
          cnt_next   = '0;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    rgb_ready_next = (state_next == GET_R) || (state_next == GET_G) || (state_next == GET_B);
    gs_valid_next  = (state_next == OUT);
    gs_done_next   = (state_next == DONE);
  end

endmodule
